// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-requester ALU share controller: op codes, FSM states
// and default widths.
package alu_share_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_OPW   = 3;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_BR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

endpackage

// File: rtl/alu_share_ctrl_alu_core.sv
// Combinational ALU shared by both requesters. Branch compare is unsigned and its
// result word is forced to zero.
module alu_core
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned OPW   = DEF_OPW
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] result,
    output logic             branch
);

    always_comb begin
        result = '0;
        branch = 1'b0;
        case (op)
            OPW'(ALU_ADD): result = a + b;
            OPW'(ALU_SUB): result = a - b;
            OPW'(ALU_BR):  branch = (a < b);
            OPW'(ALU_AND): result = a & b;
            OPW'(ALU_OR):  result = a | b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin share of one ALU between the execute slot (port 0) and the auxiliary
// unit (port 1); one operation in flight, response held until consumed.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned OPW   = DEF_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_branch
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [OPW-1:0]   opc_q;
    logic             opid_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_branch_q, rsp_id_q;
    logic [1:0]       grant;
    logic             grant_ok, accept, sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_branch;

    // Grant window also closed while reset is held so req_ready reads 00 immediately.
    always_comb begin
        grant    = 2'b00;
        grant_ok = rst_n && ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
        if (grant_ok) begin
            if (req_valid == 2'b11) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
        accept = |grant;
        sel    = grant[1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = StExec;
            StExec: state_d = StResp;
            StResp: if (rsp_ready) state_d = accept ? StExec : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            opid_q       <= 1'b0;
            rsp_result_q <= '0;
            rsp_branch_q <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= sel;
                opa_q        <= sel ? req1_a  : req0_a;
                opb_q        <= sel ? req1_b  : req0_b;
                opc_q        <= sel ? req1_op : req0_op;
                opid_q       <= sel;
            end
            if (state_q == StExec) begin
                rsp_result_q <= alu_result;
                rsp_branch_q <= alu_branch;
                rsp_id_q     <= opid_q;
            end
        end
    end

    alu_core #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .a      (opa_q),
        .b      (opb_q),
        .op     (opc_q),
        .result (alu_result),
        .branch (alu_branch)
    );

    assign req_ready  = grant;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_result = rsp_result_q;
    assign rsp_branch = rsp_branch_q;
    assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl: arbitration order, ALU results,
// backpressure and asynchronous reset.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_branch;
    logic [31:0] rsp_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_branch (rsp_branch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [31:0] res,
                             input logic br);
        check({tag, ".valid"},  {31'd0, rsp_valid}, 32'd1);
        check({tag, ".id"},     {31'd0, rsp_id}, {31'd0, id});
        check({tag, ".result"}, rsp_result, res);
        check({tag, ".branch"}, {31'd0, rsp_branch}, {31'd0, br});
    endtask

    // Single op from IDLE on one port, consumed immediately.
    task automatic do_op(input string tag, input logic port, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] res, input logic br);
        if (port) begin
            req1_a = a; req1_b = b; req1_op = op; req_valid = 2'b10;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req_valid = 2'b01;
        end
        rsp_ready = 1'b1;
        step();
        req_valid = 2'b00;
        step();
        check_rsp(tag, port, res, br);
        step();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        #1;
        check("rst.valid",  {31'd0, rsp_valid}, 32'd0);
        check("rst.result", rsp_result, 32'd0);
        check("rst.ready",  {30'd0, req_ready}, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Basic add, port 0.
        req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'b000;
        req_valid = 2'b01; rsp_ready = 1'b1;
        #1;
        check("add.ready", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b00;
        check("add.exec_valid", {31'd0, rsp_valid}, 32'd0);
        check("add.exec_ready", {30'd0, req_ready}, 32'd0);
        step();
        check_rsp("add", 1'b0, 32'd8, 1'b0);
        step();
        check("add.idle", {31'd0, rsp_valid}, 32'd0);

        // Reset so the first tie goes to port 0, then alternate under constant contention.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req0_a = 32'd3; req0_b = 32'd5; req0_op = 3'b001;
        req1_a = 32'd2; req1_b = 32'd9; req1_op = 3'b010;
        req_valid = 2'b11; rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr%0d.grant", k), {30'd0, req_ready},
                  (k % 2 == 0) ? 32'd1 : 32'd2);
            step();
            check($sformatf("rr%0d.exec", k), {30'd0, req_ready}, 32'd0);
            step();
            if (k % 2 == 0) check_rsp($sformatf("rr%0d", k), 1'b0, 32'hFFFF_FFFE, 1'b0);
            else            check_rsp($sformatf("rr%0d", k), 1'b1, 32'd0, 1'b1);
        end
        req_valid = 2'b00;
        step();

        // Backpressure with port 1 pending.
        req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
        req_valid = 2'b01; rsp_ready = 1'b0;
        step();
        req1_a = 32'h0000_000A; req1_b = 32'h0000_0005; req1_op = 3'b100;
        req_valid = 2'b10;
        step();
        for (int k = 0; k < 4; k++) begin
            check_rsp($sformatf("bp%0d", k), 1'b0, 32'd2, 1'b0);
            check($sformatf("bp%0d.ready", k), {30'd0, req_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.release_ready", {30'd0, req_ready}, 32'd2);
        step();
        req_valid = 2'b00;
        check("bp.exec_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        check_rsp("bp.next", 1'b1, 32'h0000_000F, 1'b0);
        step();

        do_op("and",   1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'hF000_F000, 1'b0);
        do_op("or",    1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'hFFF0_FFF0, 1'b0);
        do_op("op7",   1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b111, 32'd0, 1'b0);
        do_op("br_gt", 1'b1, 32'd9, 32'd2, 3'b010, 32'd0, 1'b0);
        do_op("br_eq", 1'b0, 32'd7, 32'd7, 3'b010, 32'd0, 1'b0);
        do_op("br_us", 1'b1, 32'd0, 32'hFFFF_FFFF, 3'b010, 32'd0, 1'b1);
        do_op("addwr", 1'b0, 32'hFFFF_FFFF, 32'd2, 3'b000, 32'd1, 1'b0);

        // Reset while EXEC: the op must never surface.
        req0_a = 32'd4; req0_b = 32'd4; req0_op = 3'b000;
        req_valid = 2'b01; rsp_ready = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("rx.valid", {31'd0, rsp_valid}, 32'd0);
        check("rx.ready", {30'd0, req_ready}, 32'd0);
        req_valid = 2'b00;
        #2;
        rst_n = 1'b1;
        step();
        step();
        check("rx.no_rsp", {31'd0, rsp_valid}, 32'd0);

        // Reset while RESP holds a nonzero response from port 1.
        req1_a = 32'h1234_0000; req1_b = 32'h0000_5678; req1_op = 3'b100;
        req_valid = 2'b10; rsp_ready = 1'b0;
        step();
        req_valid = 2'b00;
        step();
        check_rsp("rr.pre", 1'b1, 32'h1234_5678, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rr.valid",  {31'd0, rsp_valid}, 32'd0);
        check("rr.result", rsp_result, 32'd0);
        check("rr.id",     {31'd0, rsp_id}, 32'd0);
        #2;
        rst_n = 1'b1;
        req_valid = 2'b11; rsp_ready = 1'b1;
        #1;
        check("rr.tie", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b00;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
